// File: rtl/demux2_buffered.sv
// Steers words from one shared line into two independent 2-entry FIFO channels,
// each with a valid/ready output, a full flag and a sticky overflow flag.

module demux2_buffered_chan #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         sel,
    input  logic         ready,
    input  logic         clr_ovf,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full,
    output logic         ovf
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] out_q, out_d;
    logic         pop;
    logic         push;
    logic         drop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        out_d    = out_q;

        // A pop on a full FIFO frees the slot the same-edge write lands in.
        pop  = (count_q != 2'd0) && ready;
        push = sel && ((count_q != 2'd2) || pop);
        drop = sel && !push;

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        // Output register tracks the head; it keeps the last popped word when empty.
        if (count_d != 2'd0) begin
            out_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
        end
    end

    assign dout  = out_q;
    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'd2);
    assign ovf   = ovf_q;

endmodule

module demux2_buffered #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         MasterClock,
    input  logic         RESET,
    input  logic [W-1:0] IN,
    input  logic         SEL1,
    input  logic         SEL2,
    output logic [W-1:0] OUT1,
    output logic         VALID1,
    input  logic         READY1,
    output logic         FULL1,
    output logic         OVF1,
    output logic [W-1:0] OUT2,
    output logic         VALID2,
    input  logic         READY2,
    output logic         FULL2,
    output logic         OVF2,
    input  logic         CLR_OVF
);

    // Channel storage is hard-wired to two entries; DEPTH is informational only.
    localparam int DEPTH_UNUSED = DEPTH;

    demux2_buffered_chan #(.W(W)) u_chan1 (
        .clk     (MasterClock),
        .reset   (RESET),
        .din     (IN),
        .sel     (SEL1),
        .ready   (READY1),
        .clr_ovf (CLR_OVF),
        .dout    (OUT1),
        .valid   (VALID1),
        .full    (FULL1),
        .ovf     (OVF1)
    );

    demux2_buffered_chan #(.W(W)) u_chan2 (
        .clk     (MasterClock),
        .reset   (RESET),
        .din     (IN),
        .sel     (SEL2),
        .ready   (READY2),
        .clr_ovf (CLR_OVF),
        .dout    (OUT2),
        .valid   (VALID2),
        .full    (FULL2),
        .ovf     (OVF2)
    );

endmodule

// File: tb/tb_demux2_buffered.sv
// Directed table-driven bench for demux2_buffered: one row per clock edge with
// hand-computed expected outputs after that edge, plus a short hand sequence.

module tb_demux2_buffered;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        sel1, sel2, rdy1, rdy2, clr;
    logic [15:0] out1, out2;
    logic        valid1, full1, ovf1;
    logic        valid2, full2, ovf2;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        rst;
        logic [15:0] din;
        logic        sel1, sel2, rdy1, rdy2, clr;
        logic [15:0] e_out1;
        logic        e_v1, e_f1, e_o1;
        logic [15:0] e_out2;
        logic        e_v2, e_f2, e_o2;
    } vec_t;

    vec_t vecs[$];

    demux2_buffered #(.W(16), .DEPTH(2)) dut (
        .MasterClock (clk),
        .RESET       (rst),
        .IN          (din),
        .SEL1        (sel1),
        .SEL2        (sel2),
        .OUT1        (out1),
        .VALID1      (valid1),
        .READY1      (rdy1),
        .FULL1       (full1),
        .OVF1        (ovf1),
        .OUT2        (out2),
        .VALID2      (valid2),
        .READY2      (rdy2),
        .FULL2       (full2),
        .OVF2        (ovf2),
        .CLR_OVF     (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [15:0] d,
                          input logic s1, input logic s2, input logic r1,
                          input logic r2, input logic c,
                          input logic [15:0] o1, input logic v1, input logic f1, input logic ov1,
                          input logic [15:0] o2, input logic v2, input logic f2, input logic ov2);
        vec_t v;
        v.rst = r; v.din = d; v.sel1 = s1; v.sel2 = s2; v.rdy1 = r1; v.rdy2 = r2; v.clr = c;
        v.e_out1 = o1; v.e_v1 = v1; v.e_f1 = f1; v.e_o1 = ov1;
        v.e_out2 = o2; v.e_v2 = v2; v.e_f2 = f2; v.e_o2 = ov2;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs on the falling edge and lets the rising edge take them.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst  = v.rst;
        din  = v.din;
        sel1 = v.sel1;
        sel2 = v.sel2;
        rdy1 = v.rdy1;
        rdy2 = v.rdy2;
        clr  = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [39:0] act;
        logic [39:0] exp;
        act = {out1, valid1, full1, ovf1, 1'b0, out2, valid2, full2, ovf2, 1'b0};
        exp = {v.e_out1, v.e_v1, v.e_f1, v.e_o1, 1'b0, v.e_out2, v.e_v2, v.e_f2, v.e_o2, 1'b0};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got out1=%h v1=%b f1=%b ovf1=%b out2=%h v2=%b f2=%b ovf2=%b, expected out1=%h v1=%b f1=%b ovf1=%b out2=%h v2=%b f2=%b ovf2=%b",
                     name, out1, valid1, full1, ovf1, out2, valid2, full2, ovf2,
                     v.e_out1, v.e_v1, v.e_f1, v.e_o1, v.e_out2, v.e_v2, v.e_f2, v.e_o2);
        end
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; din = '0; sel1 = 0; sel2 = 0; rdy1 = 0; rdy2 = 0; clr = 0;

        //      rst din      s1 s2 r1 r2 clr | out1    v f o | out2    v f o
        addVec(1, 16'h0000, 0, 0, 0, 0, 0,  16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        addVec(1, 16'h0000, 0, 0, 0, 0, 0,  16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            addVec(0, 16'h0000, 0, 0, 0, 0, 0,  16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        addVec(0, 16'h1234, 1, 0, 0, 0, 0,  16'h1234, 1, 0, 0, 16'h0000, 0, 0, 0);
        addVec(0, 16'h0000, 0, 0, 1, 0, 0,  16'h1234, 0, 0, 0, 16'h0000, 0, 0, 0);
        addVec(0, 16'hAAAA, 0, 1, 0, 0, 0,  16'h1234, 0, 0, 0, 16'hAAAA, 1, 0, 0);
        addVec(0, 16'hBBBB, 0, 1, 0, 0, 0,  16'h1234, 0, 0, 0, 16'hAAAA, 1, 1, 0);
        addVec(0, 16'hCCCC, 0, 1, 0, 0, 0,  16'h1234, 0, 0, 0, 16'hAAAA, 1, 1, 1);
        addVec(0, 16'h0000, 0, 0, 0, 1, 0,  16'h1234, 0, 0, 0, 16'hBBBB, 1, 0, 1);
        addVec(0, 16'h0000, 0, 0, 0, 1, 0,  16'h1234, 0, 0, 0, 16'hBBBB, 0, 0, 1);
        addVec(0, 16'h0000, 0, 0, 0, 0, 1,  16'h1234, 0, 0, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h0001, 1, 0, 0, 0, 0,  16'h0001, 1, 0, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h0002, 1, 0, 0, 0, 0,  16'h0001, 1, 1, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h0003, 1, 0, 1, 0, 0,  16'h0002, 1, 1, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h0000, 0, 0, 1, 0, 0,  16'h0003, 1, 0, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h0000, 0, 0, 1, 0, 0,  16'h0003, 0, 0, 0, 16'hBBBB, 0, 0, 0);
        addVec(0, 16'h5A5A, 1, 1, 0, 0, 0,  16'h5A5A, 1, 0, 0, 16'h5A5A, 1, 0, 0);
        addVec(0, 16'h0000, 0, 0, 1, 1, 0,  16'h5A5A, 0, 0, 0, 16'h5A5A, 0, 0, 0);
        addVec(0, 16'h1111, 1, 0, 0, 0, 0,  16'h1111, 1, 0, 0, 16'h5A5A, 0, 0, 0);
        addVec(0, 16'h2222, 1, 0, 0, 0, 0,  16'h1111, 1, 1, 0, 16'h5A5A, 0, 0, 0);
        addVec(0, 16'h3333, 1, 1, 0, 0, 0,  16'h1111, 1, 1, 1, 16'h3333, 1, 0, 0);
        addVec(0, 16'h4444, 0, 1, 0, 0, 0,  16'h1111, 1, 1, 1, 16'h3333, 1, 1, 0);
        addVec(0, 16'h5555, 0, 1, 0, 0, 0,  16'h1111, 1, 1, 1, 16'h3333, 1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset lands while FIFO 1 is full and OVF2 is set; the strobed word must vanish.
        v = '{rst:1, din:16'h6666, sel1:1, sel2:0, rdy1:0, rdy2:0, clr:0,
              e_out1:16'h0000, e_v1:0, e_f1:0, e_o1:0, e_out2:16'h0000, e_v2:0, e_f2:0, e_o2:0};
        applyStimulus(v);
        checkOutput("reset_mid_op", v);
        v = '{rst:0, din:16'h0000, sel1:0, sel2:0, rdy1:0, rdy2:0, clr:0,
              e_out1:16'h0000, e_v1:0, e_f1:0, e_o1:0, e_out2:16'h0000, e_v2:0, e_f2:0, e_o2:0};
        applyStimulus(v);
        checkOutput("after_reset_idle", v);

        // Write plus ready on an empty FIFO, then write plus pop at count 1.
        v = '{rst:0, din:16'h7777, sel1:1, sel2:0, rdy1:1, rdy2:1, clr:0,
              e_out1:16'h7777, e_v1:1, e_f1:0, e_o1:0, e_out2:16'h0000, e_v2:0, e_f2:0, e_o2:0};
        applyStimulus(v);
        checkOutput("wr_rd_empty", v);
        v = '{rst:0, din:16'h8888, sel1:1, sel2:0, rdy1:1, rdy2:0, clr:0,
              e_out1:16'h8888, e_v1:1, e_f1:0, e_o1:0, e_out2:16'h0000, e_v2:0, e_f2:0, e_o2:0};
        applyStimulus(v);
        checkOutput("wr_rd_count1", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
